// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte sources.
// Each granted byte is relaunched on NAK or timeout until MAX_RETRY retries are used up.
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int WORD_LENGTH = 8,
    parameter int MAX_RETRY   = 3,
    parameter int ACK_TIMEOUT = 2048
) (
    input  logic                           t_clk,
    input  logic                           t_rst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*WORD_LENGTH-1:0] req_data,
    output logic [NUM_REQ-1:0]             gnt,
    output logic [NUM_REQ-1:0]             done,
    output logic [NUM_REQ-1:0]             fail,
    output logic                           tx_start,
    output logic [WORD_LENGTH-1:0]         tx_data,
    input  logic                           tx_busy,
    input  logic                           ack_valid,
    input  logic                           err_ack,
    output logic                           busy
);

    localparam int PTR_W   = $clog2(NUM_REQ);
    localparam int TIMER_W = $clog2(ACK_TIMEOUT + 1);
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [PTR_W-1:0]   PTR_RESET  = PTR_W'(NUM_REQ - 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(ACK_TIMEOUT - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT_ACK
    } state_t;

    state_t                   state_q, state_d;
    logic [PTR_W-1:0]         ptr_q, ptr_d;
    logic [PTR_W-1:0]         idx_q, idx_d;
    logic [TIMER_W-1:0]       timer_q, timer_d;
    logic [RETRY_W-1:0]       retry_cnt_q, retry_cnt_d;
    logic [WORD_LENGTH-1:0]   data_q, data_d;
    logic [NUM_REQ-1:0]       gnt_q, gnt_d;
    logic [NUM_REQ-1:0]       done_q, done_d;
    logic [NUM_REQ-1:0]       fail_q, fail_d;
    logic                     tx_start_q, tx_start_d;
    logic                     busy_q, busy_d;

    logic [WORD_LENGTH-1:0]   req_bytes [NUM_REQ];
    logic [NUM_REQ-1:0]       pick_onehot;
    logic [NUM_REQ-1:0]       idx_onehot;
    logic                     pick_found;
    logic [PTR_W-1:0]         pick_idx;
    logic                     hi_found;
    logic [PTR_W-1:0]         hi_idx;
    logic                     lo_found;
    logic [PTR_W-1:0]         lo_idx;
    logic                     attempt_err;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_bytes[gi]   = req_data[gi*WORD_LENGTH +: WORD_LENGTH];
            assign pick_onehot[gi] = (pick_idx == PTR_W'(gi));
            assign idx_onehot[gi]  = (idx_q == PTR_W'(gi));
        end
    endgenerate

    // Lowest requester above ptr wins; otherwise wrap to the lowest at or below ptr.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_found = 1'b0;
        lo_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                if (i > int'(ptr_q)) begin
                    hi_found = 1'b1;
                    hi_idx   = PTR_W'(i);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = PTR_W'(i);
                end
            end
        end
        pick_found = hi_found | lo_found;
        pick_idx   = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        timer_d     = timer_q;
        retry_cnt_d = retry_cnt_q;
        data_d      = data_q;
        gnt_d       = '0;
        done_d      = '0;
        fail_d      = '0;
        tx_start_d  = 1'b0;
        attempt_err = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    idx_d       = pick_idx;
                    ptr_d       = pick_idx;
                    data_d      = req_bytes[pick_idx];
                    retry_cnt_d = '0;
                    gnt_d       = pick_onehot;
                    state_d     = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    timer_d    = '0;
                    state_d    = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                timer_d = timer_q + TIMER_W'(1);
                // A verdict on the timeout edge is honoured ahead of the timeout.
                if (ack_valid && !err_ack) begin
                    done_d  = idx_onehot;
                    state_d = ST_IDLE;
                end else if (ack_valid || (timer_q == TIMER_LAST)) begin
                    attempt_err = 1'b1;
                end

                if (attempt_err) begin
                    if (retry_cnt_q < RETRY_MAX) begin
                        retry_cnt_d = retry_cnt_q + RETRY_W'(1);
                        state_d     = ST_LAUNCH;
                    end else begin
                        fail_d  = idx_onehot;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge t_clk) begin
        if (t_rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= PTR_RESET;
            idx_q       <= '0;
            timer_q     <= '0;
            retry_cnt_q <= '0;
            data_q      <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            fail_q      <= '0;
            tx_start_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            timer_q     <= timer_d;
            retry_cnt_q <= retry_cnt_d;
            data_q      <= data_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
            tx_start_q  <= tx_start_d;
            busy_q      <= busy_d;
        end
    end

    assign gnt      = gnt_q;
    assign done     = done_q;
    assign fail     = fail_q;
    assign tx_start = tx_start_q;
    assign tx_data  = data_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: grant order, retries, timeout, busy stall and reset.
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int WL = 8;
    localparam int MR = 3;
    localparam int TO = 16;

    logic              t_clk = 1'b0;
    logic              t_rst;
    logic [NR-1:0]     req;
    logic [NR*WL-1:0]  req_data;
    logic [NR-1:0]     gnt;
    logic [NR-1:0]     done;
    logic [NR-1:0]     fail;
    logic              tx_start;
    logic [WL-1:0]     tx_data;
    logic              tx_busy;
    logic              ack_valid;
    logic              err_ack;
    logic              busy;

    int checks = 0;
    int errors = 0;

    int            n_start;
    int            n_done;
    int            n_fail;
    logic [NR-1:0] done_acc;
    logic [NR-1:0] fail_acc;
    logic [WL-1:0] data_log [$];

    uart_tx_arbiter #(
        .NUM_REQ    (NR),
        .WORD_LENGTH(WL),
        .MAX_RETRY  (MR),
        .ACK_TIMEOUT(TO)
    ) dut (
        .t_clk    (t_clk),
        .t_rst    (t_rst),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .done     (done),
        .fail     (fail),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .ack_valid(ack_valid),
        .err_ack  (err_ack),
        .busy     (busy)
    );

    always #5 t_clk = ~t_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Advance one cycle and log what the DUT shows in the new cycle.
    task automatic step();
        @(posedge t_clk);
        #1;
        if (tx_start) begin
            n_start++;
            data_log.push_back(tx_data);
        end
        if (done != '0) begin
            n_done++;
            done_acc |= done;
            $display("txn: done=%b data=%h t=%0t", done, tx_data, $time);
        end
        if (fail != '0) begin
            n_fail++;
            fail_acc |= fail;
            $display("txn: fail=%b data=%h t=%0t", fail, tx_data, $time);
        end
    endtask

    task automatic clear_mon();
        n_start  = 0;
        n_done   = 0;
        n_fail   = 0;
        done_acc = '0;
        fail_acc = '0;
        data_log.delete();
    endtask

    task automatic apply_reset();
        t_rst     = 1'b1;
        req       = '0;
        tx_busy   = 1'b0;
        ack_valid = 1'b0;
        err_ack   = 1'b0;
        step();
        step();
        t_rst = 1'b0;
        clear_mon();
    endtask

    task automatic wait_start(input int max, output bit ok);
        int i = 0;
        while (!tx_start && i < max) begin
            step();
            i++;
        end
        ok = tx_start;
    endtask

    task automatic wait_gnt(input int max, output bit ok);
        int i = 0;
        while (gnt == '0 && i < max) begin
            step();
            i++;
        end
        ok = (gnt != '0);
    endtask

    // Wait for a launch, then return a verdict `delay` cycles into WAIT_ACK.
    task automatic serve(input logic err, input int delay, output bit ok);
        wait_start(100, ok);
        if (!ok) return;
        repeat (delay) step();
        ack_valid = 1'b1;
        err_ack   = err;
        step();
        ack_valid = 1'b0;
        err_ack   = 1'b0;
    endtask

    task automatic test_reset();
        t_rst     = 1'b1;
        req       = '0;
        req_data  = '0;
        tx_busy   = 1'b0;
        ack_valid = 1'b0;
        err_ack   = 1'b0;
        clear_mon();
        step();
        step();
        checks++;
        if ({gnt, done, fail, tx_start, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0", {gnt, done, fail, tx_start, busy});
        end
        checks++;
        if (tx_data !== '0) begin
            errors++;
            $display("FAIL reset_tx_data: got %h expected 00", tx_data);
        end
        t_rst = 1'b0;
        clear_mon();
    endtask

    task automatic test_single();
        bit ok;
        req_data[2*WL +: WL] = 8'hA5;
        req = 4'b0100;
        step();
        checks++;
        if (gnt !== 4'b0100 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_gnt: got gnt=%b busy=%b expected gnt=0100 busy=1", gnt, busy);
        end
        req = '0;
        step();
        checks++;
        if (gnt !== 4'b0000 || tx_start !== 1'b1 || tx_data !== 8'hA5) begin
            errors++;
            $display("FAIL single_launch: got gnt=%b tx_start=%b data=%h expected 0000 1 a5",
                     gnt, tx_start, tx_data);
        end
        serve(1'b0, 6, ok);
        checks++;
        if (!ok || done !== 4'b0100 || busy !== 1'b0 || fail !== 4'b0000) begin
            errors++;
            $display("FAIL single_done: got ok=%0d done=%b busy=%b fail=%b expected 1 0100 0 0000",
                     ok, done, busy, fail);
        end
        repeat (3) step();
        checks++;
        if (n_start != 1 || n_done != 1 || n_fail != 0) begin
            errors++;
            $display("FAIL single_counts: got starts=%0d dones=%0d fails=%0d expected 1 1 0",
                     n_start, n_done, n_fail);
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        logic [NR-1:0] exp_oh;
        logic [WL-1:0] exp_byte;
        apply_reset();
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            exp_oh   = NR'(1 << (t % NR));
            exp_byte = WL'(16 + (t % NR));
            wait_gnt(10, ok);
            checks++;
            if (!ok || gnt !== exp_oh) begin
                errors++;
                $display("FAIL rr_gnt_%0d: got %b expected %b", t, gnt, exp_oh);
            end
            if (t == 4) req = '0;
            serve(1'b0, 2, ok);
            checks++;
            if (!ok || done !== exp_oh) begin
                errors++;
                $display("FAIL rr_done_%0d: got %b expected %b", t, done, exp_oh);
            end
            checks++;
            if (tx_data !== exp_byte) begin
                errors++;
                $display("FAIL rr_data_%0d: got %h expected %h", t, tx_data, exp_byte);
            end
        end
    endtask

    task automatic test_retry();
        bit ok1, ok2, ok3;
        apply_reset();
        req_data[1*WL +: WL] = 8'h3C;
        req = 4'b0010;
        wait_gnt(10, ok1);
        req = '0;
        serve(1'b1, 3, ok1);
        serve(1'b1, 3, ok2);
        serve(1'b0, 3, ok3);
        checks++;
        if (!(ok1 && ok2 && ok3) || done !== 4'b0010) begin
            errors++;
            $display("FAIL retry_done: got ok=%0d%0d%0d done=%b expected 111 0010",
                     ok1, ok2, ok3, done);
        end
        repeat (3) step();
        checks++;
        if (n_start != 3 || n_done != 1 || n_fail != 0 || done_acc !== 4'b0010) begin
            errors++;
            $display("FAIL retry_counts: got starts=%0d dones=%0d fails=%0d expected 3 1 0",
                     n_start, n_done, n_fail);
        end
        for (int i = 0; i < data_log.size(); i++) begin
            checks++;
            if (data_log[i] !== 8'h3C) begin
                errors++;
                $display("FAIL retry_data_%0d: got %h expected 3c", i, data_log[i]);
            end
        end
    endtask

    task automatic test_exhaust();
        bit ok;
        bit all_ok = 1'b1;
        apply_reset();
        req_data[3*WL +: WL] = 8'h77;
        req = 4'b1000;
        wait_gnt(10, ok);
        req = '0;
        for (int a = 0; a <= MR; a++) begin
            serve(1'b1, 2, ok);
            all_ok &= ok;
        end
        checks++;
        if (!all_ok || fail !== 4'b1000 || busy !== 1'b0 || done !== 4'b0000) begin
            errors++;
            $display("FAIL exhaust_fail: got ok=%0d fail=%b busy=%b done=%b expected 1 1000 0 0000",
                     all_ok, fail, busy, done);
        end
        repeat (20) step();
        checks++;
        if (n_start != MR + 1 || n_fail != 1 || n_done != 0 || fail_acc !== 4'b1000) begin
            errors++;
            $display("FAIL exhaust_counts: got starts=%0d fails=%0d dones=%0d expected 4 1 0",
                     n_start, n_fail, n_done);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int gap;
        apply_reset();
        req_data[0 +: WL] = 8'h5A;
        req = 4'b0001;
        wait_gnt(10, ok);
        req = '0;
        wait_start(10, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL timeout_first_start: got none expected tx_start");
        end
        for (int r = 1; r <= MR; r++) begin
            step();
            gap = 1;
            while (!tx_start && gap < 40) begin
                step();
                gap++;
            end
            checks++;
            if (gap != TO + 1) begin
                errors++;
                $display("FAIL timeout_gap_%0d: got %0d expected %0d", r, gap, TO + 1);
            end
        end
        gap = 0;
        do begin
            step();
            gap++;
        end while (fail == '0 && gap < 40);
        checks++;
        if (gap != TO || fail !== 4'b0001 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_fail: got gap=%0d fail=%b busy=%b expected %0d 0001 0",
                     gap, fail, busy, TO);
        end
        checks++;
        if (n_start != MR + 1 || n_done != 0) begin
            errors++;
            $display("FAIL timeout_counts: got starts=%0d dones=%0d expected 4 0", n_start, n_done);
        end

        clear_mon();
        req_data[2*WL +: WL] = 8'hC3;
        req = 4'b0100;
        wait_gnt(10, ok);
        req = '0;
        serve(1'b0, TO - 1, ok);
        checks++;
        if (!ok || done !== 4'b0100 || fail !== 4'b0000) begin
            errors++;
            $display("FAIL race_done: got done=%b fail=%b expected 0100 0000", done, fail);
        end
        repeat (TO + 4) step();
        checks++;
        if (n_start != 1 || n_fail != 0 || n_done != 1) begin
            errors++;
            $display("FAIL race_counts: got starts=%0d fails=%0d dones=%0d expected 1 0 1",
                     n_start, n_fail, n_done);
        end
    endtask

    task automatic test_busy_reset();
        bit ok;
        apply_reset();
        tx_busy = 1'b1;
        req_data[0 +: WL] = 8'h99;
        req = 4'b0001;
        wait_gnt(10, ok);
        checks++;
        if (!ok || gnt !== 4'b0001) begin
            errors++;
            $display("FAIL busy_gnt: got %b expected 0001", gnt);
        end
        req = '0;
        repeat (50) step();
        checks++;
        if (n_start != 0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_hold: got starts=%0d busy=%b expected 0 1", n_start, busy);
        end
        tx_busy = 1'b0;
        step();
        checks++;
        if (tx_start !== 1'b1 || tx_data !== 8'h99) begin
            errors++;
            $display("FAIL busy_release: got tx_start=%b data=%h expected 1 99", tx_start, tx_data);
        end
        repeat (3) step();
        t_rst = 1'b1;
        step();
        t_rst = 1'b0;
        checks++;
        if ({gnt, done, fail, tx_start, busy} !== '0 || tx_data !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got %b data=%h expected 0 00",
                     {gnt, done, fail, tx_start, busy}, tx_data);
        end
        repeat (TO + 8) step();
        checks++;
        if (n_done != 0 || n_fail != 0 || n_start != 1) begin
            errors++;
            $display("FAIL midreset_abandon: got dones=%0d fails=%0d starts=%0d expected 0 0 1",
                     n_done, n_fail, n_start);
        end
        req_data[1*WL +: WL] = 8'h21;
        req = 4'b1010;
        wait_gnt(10, ok);
        checks++;
        if (!ok || gnt !== 4'b0010) begin
            errors++;
            $display("FAIL midreset_priority: got %b expected 0010", gnt);
        end
        req = '0;
        serve(1'b0, 1, ok);
        checks++;
        if (!ok || done !== 4'b0010) begin
            errors++;
            $display("FAIL midreset_done: got %b expected 0010", done);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_retry();
        test_exhaust();
        test_timeout();
        test_busy_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
